// File: rtl/alu_pkg.sv
// ALU control codes and execute-stage FSM state encoding.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

endpackage : alu_pkg

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier producing the low XLEN bits of A*B.
// Optional build macro: MUL_EARLY_EXIT_EN (finish once the remaining multiplier bits are zero).
module mul_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_o,
    output logic [XLEN-1:0] acc_o
);

    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(XLEN - 1));

    // Flags the iteration being performed this cycle as the final one.
`ifdef MUL_EARLY_EXIT_EN
    assign last_o = cnt_last || ((mplier_q >> 1) == '0);
`else
    assign last_o = cnt_last;
`endif

    assign acc_o = acc_q;

    // Load operands on start, otherwise perform one shift-add iteration per step.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            mcand_d  = '0;
            mplier_d = '0;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule : mul_seq

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, multi-cycle MUL with pipeline stall.
// Optional build macro: MUL_EARLY_EXIT_EN (passed through to mul_seq).
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl_i,
    input  logic [XLEN-1:0]       src_a_i,
    input  logic [XLEN-1:0]       src_b_i,
    output logic [XLEN-1:0]       result_o,
    output logic                  zero_o,
    output logic                  stall_o
);

    ex_state_e       state_q, state_d;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] mul_acc;
    logic            mul_last;
    logic            mul_start;
    logic            mul_step;
    logic            is_mul;

    assign is_mul = (alu_ctrl_i == ALU_MUL);

    // Single-cycle operations; MUL and unknown codes give 0 here.
    always_comb begin
        comb_res = '0;
        case (alu_ctrl_i)
            ALU_AND: comb_res = src_a_i & src_b_i;
            ALU_OR:  comb_res = src_a_i | src_b_i;
            ALU_ADD: comb_res = src_a_i + src_b_i;
            ALU_SUB: comb_res = src_a_i - src_b_i;
            ALU_SLT: comb_res = XLEN'($signed(src_a_i) < $signed(src_b_i));
            default: comb_res = '0;
        endcase
    end

    mul_seq #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_i),
        .start_i (mul_start),
        .step_i  (mul_step),
        .a_i     (src_a_i),
        .b_i     (src_b_i),
        .last_o  (mul_last),
        .acc_o   (mul_acc)
    );

    // Next-state, stall and result selection; reset and flush override everything.
    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        result_o  = comb_res;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && is_mul) begin
                    stall_o   = 1'b1;
                    mul_start = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_o  = 1'b1;
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_o = mul_acc;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d   = ST_IDLE;
            stall_o   = 1'b0;
            mul_start = 1'b0;
            mul_step  = 1'b0;
        end
        if (rst) begin
            state_d  = ST_IDLE;
            stall_o  = 1'b0;
            result_o = '0;
        end
    end

    assign zero_o = (result_o == '0);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule : alu_exec

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: random ops against a behavioural model plus directed MUL/flush/reset cases.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic            flush_i;
    logic [3:0]      alu_ctrl_i;
    logic [XLEN-1:0] src_a_i;
    logic [XLEN-1:0] src_b_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .flush_i    (flush_i),
        .alu_ctrl_i (alu_ctrl_i),
        .src_a_i    (src_a_i),
        .src_b_i    (src_b_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .stall_o    (stall_o)
    );

    // Reference: what each code should produce, straight from the operation definitions.
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] code, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return XLEN'(64'(a) + 64'(b));
            4'b0110: return XLEN'(64'(a) - 64'(b));
            4'b1000: return (sa < sb) ? XLEN'(1) : XLEN'(0);
            4'b1001: return XLEN'(64'(a) * 64'(b));
            default: return '0;
        endcase
    endfunction

    // Expected number of BUSY cycles for a multiply with multiplier b.
    function automatic int exp_busy(input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int n;
        n = 1;
        for (int i = 0; i < int'(XLEN); i++) if (b[i]) n = i + 1;
        return n;
`else
        return (b == 0) ? int'(XLEN) : int'(XLEN);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] code, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
        valid_i    = v;
        alu_ctrl_i = code;
        src_a_i    = a;
        src_b_i    = b;
    endtask

    // One combinational op: drive, sample mid-cycle, compare result/zero/stall.
    task automatic check_comb(input string name, input logic [3:0] code, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] exp;
        step();
        drive(1'b1, code, a, b);
        exp = ref_alu(code, a, b);
        @(negedge clk);
        n_tests++;
        if (result_o !== exp || zero_o !== (exp == 0) || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s code=%b a=%h b=%h: got res=%h zero=%b stall=%b, want res=%h zero=%b stall=0",
                     name, code, a, b, result_o, zero_o, stall_o, exp, (exp == 0));
        end
    endtask

    // Full multiply: issue, count BUSY cycles, check product in DONE, then confirm no restart.
    task automatic run_mul(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input bit drop_valid);
        int busy;
        bit done;
        busy = 0;
        done = 0;
        step();
        drive(1'b1, ALU_MUL, a, b);
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_issue_stall: got %b want 1", name, stall_o);
        end
        for (int k = 0; k < int'(XLEN) + 4 && !done; k++) begin
            step();
            if (drop_valid) valid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stall_o === 1'b1) busy++;
            else done = 1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: stall still high after %0d cycles", name, busy);
        end else begin
            if (busy != exp_busy(b)) begin
                n_fail++;
                $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy, exp_busy(b));
            end
            n_tests++;
            if (result_o !== ref_alu(ALU_MUL, a, b) || zero_o !== (ref_alu(ALU_MUL, a, b) == 0)) begin
                n_fail++;
                $display("FAIL %s_product a=%h b=%h: got %h zero=%b want %h", name, a, b, result_o,
                         zero_o, ref_alu(ALU_MUL, a, b));
            end
        end
        step();
        drive(1'b0, ALU_MUL, a, b);
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL %s_after_done: got stall=%b res=%h want stall=0 res=0", name, stall_o,
                     result_o);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        flush_i = 1'b0;
        drive(1'b1, ALU_ADD, 32'd2, 32'd3);
        repeat (2) step();
        @(negedge clk);
        n_tests++;
        if (result_o !== '0 || stall_o !== 1'b0 || zero_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: got res=%h stall=%b zero=%b want 0/0/1", result_o, stall_o, zero_o);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_comb_ops();
        logic [3:0] codes [6];
        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, 4'b1111};
        check_comb("add_wrap_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        check_comb("add_wrap",     ALU_ADD, 32'hFFFF_FFFF, 32'h2);
        check_comb("sub_zero",     ALU_SUB, 32'h5, 32'h5);
        check_comb("sub_neg",      ALU_SUB, 32'h0, 32'h1);
        check_comb("slt_neg",      ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        check_comb("slt_pos",      ALU_SLT, 32'h1, 32'hFFFF_FFFF);
        check_comb("slt_equal",    ALU_SLT, 32'h8000_0000, 32'h8000_0000);
        check_comb("and",          ALU_AND, 32'hF0F0, 32'h0FF0);
        check_comb("or",           ALU_OR,  32'hF0F0, 32'h0FF0);
        check_comb("unknown",      4'b1111, 32'h1234, 32'h5678);
        for (int i = 0; i < 30; i++) begin
            logic [3:0] c;
            c = codes[$urandom_range(0, 5)];
            if (i % 5 == 4) begin
                c = 4'($urandom_range(0, 15));
                if (c == ALU_MUL) c = 4'b0011;
            end
            check_comb("rand_op", c, $urandom, $urandom);
        end
    endtask

    task automatic test_mul();
        run_mul("mul_3x5", 32'd3, 32'd5, 1'b0);
        run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mul("mul_b0", 32'h1234_5678, 32'h0, 1'b0);
        run_mul("mul_b5", 32'h0000_0011, 32'h5, 1'b0);
        for (int i = 0; i < 5; i++) run_mul("mul_rand", $urandom, $urandom >> $urandom_range(0, 31), 1'b0);
        run_mul("mul_valid_drop", $urandom, $urandom, 1'b1);
    endtask

    task automatic test_valid_low();
        step();
        drive(1'b0, ALU_MUL, 32'd7, 32'd9);
        @(negedge clk);
        step();
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_low_no_start: got stall=%b want 0", stall_o);
        end
    endtask

    task automatic test_flush();
        // Flush during BUSY cycle 10.
        step();
        drive(1'b1, ALU_MUL, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 10) flush_i = 1'b1;
            @(negedge clk);
            n_tests++;
            if (stall_o !== (k != 10)) begin
                n_fail++;
                $display("FAIL flush_busy_cycle%0d: got stall=%b want %b", k, stall_o, (k != 10));
            end
        end
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL flush_then_idle: got stall=%b res=%h want 0/0", stall_o, result_o);
        end
        run_mul("mul_after_flush", 32'd6, 32'd7, 1'b0);
        // Flush coinciding with a MUL issue: nothing starts.
        step();
        drive(1'b1, ALU_MUL, 32'd4, 32'd4);
        flush_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_issue_stall: got %b want 0", stall_o);
        end
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_issue_no_start: got stall=%b want 0", stall_o);
        end
    endtask

    task automatic test_rst_mid_mul();
        step();
        drive(1'b1, ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (stall_o !== 1'b0 || result_o !== '0) begin
                n_fail++;
                $display("FAIL rst_mid_mul: got stall=%b res=%h want 0/0", stall_o, result_o);
            end
            step();
        end
        rst = 1'b0;
        drive(1'b1, ALU_ADD, 32'd2, 32'd3);
        @(negedge clk);
        n_tests++;
        if (result_o !== 32'd5 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL add_after_rst: got res=%h stall=%b want 5/0", result_o, stall_o);
        end
        run_mul("mul_after_rst", 32'd11, 32'd13, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_mul("mul_b2b", $urandom, $urandom, 1'b0);
        check_comb("add_after_mul", ALU_ADD, 32'd100, 32'd23);
    endtask

    initial begin
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        alu_ctrl_i = '0;
        src_a_i    = '0;
        src_b_i    = '0;
        rst        = 1'b1;
        test_reset();
        test_comb_ops();
        test_mul();
        test_valid_low();
        test_flush();
        test_rst_mid_mul();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_exec
